// File: rtl/fast_window_feeder_if.sv
// Pixel-in / window-out bus of fast_window_feeder.
//   i_valid/i_sof/i_pixel : raster pixel stream from the source (no backpressure)
//   o_valid/o_last        : window strobe and end-of-frame marker
//   o_col0..o_col6        : 7x7 window columns, lane k (bits 8k+7:8k) = window row k
//   o_x/o_y               : window-centre coordinate
interface fast_window_feeder_if;
    logic        i_valid;
    logic        i_sof;
    logic [7:0]  i_pixel;
    logic        o_valid;
    logic [55:0] o_col0;
    logic [55:0] o_col1;
    logic [55:0] o_col2;
    logic [55:0] o_col3;
    logic [55:0] o_col4;
    logic [55:0] o_col5;
    logic [55:0] o_col6;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_last;

    modport master (
        output i_valid, i_sof, i_pixel,
        input  o_valid, o_col0, o_col1, o_col2, o_col3, o_col4, o_col5, o_col6,
               o_x, o_y, o_last
    );

    modport slave (
        input  i_valid, i_sof, i_pixel,
        output o_valid, o_col0, o_col1, o_col2, o_col3, o_col4, o_col5, o_col6,
               o_x, o_y, o_last
    );
endinterface

// File: rtl/fast_window_feeder.sv
// Raster pixel stream to sliding 7x7 window converter.
//   i_clk   : clock, all logic on posedge
//   i_rst_n : synchronous active-low reset (line buffers are not cleared)
//   bus     : slave side of fast_window_feeder_if (pixel in, window columns out)
// Six line buffers hold the previous six rows; a 7-entry column register holds the
// window. Output latency is one cycle from pixel accept.
module fast_window_feeder #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fast_window_feeder_if.slave  bus
);
    localparam int unsigned PW    = 8;
    localparam int unsigned LANES = 7;
    localparam int unsigned NLB   = 6;
    localparam int unsigned COLW  = PW * LANES;
    localparam int unsigned CW    = 12;
    localparam int unsigned XW    = $clog2(WIDTH);
    localparam int unsigned YW    = $clog2(HEIGHT);

    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [XW-1:0]   px_x;
    logic [YW-1:0]   px_y;
    logic [COLW-1:0] new_col;
    logic [COLW-1:0] col_q [LANES];
    logic [COLW-1:0] col_d [LANES];
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [CW-1:0]   ox_q, ox_d;
    logic [CW-1:0]   oy_q, oy_d;
    logic [PW-1:0]   lb_q [NLB][WIDTH];

    // Coordinate of the pixel being accepted; sof forces it to (0,0).
    always_comb begin
        px_x = bus.i_sof ? '0 : x_q;
        px_y = bus.i_sof ? '0 : y_q;
    end

    // New column: current pixel at the bottom lane, line buffers above it.
    always_comb begin
        new_col = '0;
        for (int unsigned j = 0; j < NLB; j++) begin
            new_col[PW*j +: PW] = lb_q[j][px_x];
        end
        new_col[PW*NLB +: PW] = bus.i_pixel;
    end

    // Counter advance, column shift and output registers; bubbles hold everything.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        if (bus.i_valid) begin
            if (px_x == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (px_y == YW'(HEIGHT - 1)) ? '0 : px_y + YW'(1);
            end else begin
                x_d = px_x + XW'(1);
                y_d = px_y;
            end
            for (int unsigned c = 0; c < LANES - 1; c++) begin
                col_d[c] = col_q[c+1];
            end
            col_d[LANES-1] = new_col;
            // Windows with x<6 straddle a row start and hold stale columns.
            valid_d = (px_x >= XW'(6)) && (px_y >= YW'(6));
            last_d  = valid_d && (px_x == XW'(WIDTH - 1)) && (px_y == YW'(HEIGHT - 1));
            ox_d    = CW'(px_x) - CW'(3);
            oy_d    = CW'(px_y) - CW'(3);
        end
    end

    // Control and window registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            for (int unsigned c = 0; c < LANES; c++) begin
                col_q[c] <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            col_q   <= col_d;
        end
    end

    // Line buffers move up one row at the accepted column; no reset on storage.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && bus.i_valid) begin
            for (int unsigned j = 0; j < NLB - 1; j++) begin
                lb_q[j][px_x] <= lb_q[j+1][px_x];
            end
            lb_q[NLB-1][px_x] <= bus.i_pixel;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_x     = ox_q;
    assign bus.o_y     = oy_q;
    assign bus.o_col0  = col_q[0];
    assign bus.o_col1  = col_q[1];
    assign bus.o_col2  = col_q[2];
    assign bus.o_col3  = col_q[3];
    assign bus.o_col4  = col_q[4];
    assign bus.o_col5  = col_q[5];
    assign bus.o_col6  = col_q[6];
endmodule

// File: tb/tb_fast_window_feeder.sv
// Self-checking bench for fast_window_feeder (WIDTH=16, HEIGHT=12).
module tb_fast_window_feeder;
    localparam int W = 16;
    localparam int H = 12;

    typedef struct packed {
        logic [6:0][55:0] cols;
        logic [11:0]      x;
        logic [11:0]      y;
        logic             last;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fast_window_feeder_if bus();

    fast_window_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          mx = 0;
    int          my = 0;
    int          valid_cnt = 0;
    logic [7:0]  img [H][W];
    win_t        exp_q [$];
    logic [55:0] prev_col [7];
    logic [11:0] prev_x;
    logic [11:0] prev_y;

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'((16 * y + x) % 256);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic obs_cols(output logic [55:0] c [7]);
        c[0] = bus.o_col0; c[1] = bus.o_col1; c[2] = bus.o_col2; c[3] = bus.o_col3;
        c[4] = bus.o_col4; c[5] = bus.o_col5; c[6] = bus.o_col6;
    endtask

    // One clock: drive inputs, update reference model, compare after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        logic        exp_v;
        win_t        w;
        logic [55:0] oc [7];
        bus.i_valid = v;
        bus.i_sof   = s;
        bus.i_pixel = p;
        exp_v = 1'b0;
        if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = p;
            if (mx >= 6 && my >= 6) begin
                for (int c = 0; c < 7; c++)
                    for (int k = 0; k < 7; k++)
                        w.cols[c][8*k +: 8] = img[my-6+k][mx-6+c];
                w.x    = 12'(mx - 3);
                w.y    = 12'(my - 3);
                w.last = (mx == W - 1) && (my == H - 1);
                exp_q.push_back(w);
                exp_v = 1'b1;
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        obs_cols(oc);
        chk("o_valid", 64'(bus.o_valid), 64'(exp_v));
        if (bus.o_valid && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            valid_cnt++;
            for (int c = 0; c < 7; c++) chk($sformatf("col%0d", c), 64'(oc[c]), 64'(w.cols[c]));
            chk("o_x", 64'(bus.o_x), 64'(w.x));
            chk("o_y", 64'(bus.o_y), 64'(w.y));
            chk("o_last", 64'(bus.o_last), 64'(w.last));
        end else begin
            chk("o_last_idle", 64'(bus.o_last), 64'd0);
        end
        if (!v) begin
            for (int c = 0; c < 7; c++) chk($sformatf("hold_col%0d", c), 64'(oc[c]), 64'(prev_col[c]));
            chk("hold_x", 64'(bus.o_x), 64'(prev_x));
            chk("hold_y", 64'(bus.o_y), 64'(prev_y));
        end
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        prev_col = oc;
        prev_x   = bus.o_x;
        prev_y   = bus.o_y;
    endtask

    task automatic do_reset();
        logic [55:0] oc [7];
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        obs_cols(oc);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_last", 64'(bus.o_last), 64'd0);
        chk("rst_x", 64'(bus.o_x), 64'd0);
        chk("rst_y", 64'(bus.o_y), 64'd0);
        for (int c = 0; c < 7; c++) chk($sformatf("rst_col%0d", c), 64'(oc[c]), 64'd0);
        mx = 0;
        my = 0;
        exp_q.delete();
        prev_col = oc;
        prev_x   = bus.o_x;
        prev_y   = bus.o_y;
        rst_n = 1'b1;
    endtask

    // Streams pixels 0..n-1 of a frame with optional bubbles and fixed-point checks.
    task automatic run_frame(input int bub_pct, input logic sof_first, input int n);
        for (int i = 0; i < n; i++) begin
            int x;
            int y;
            int nb;
            x  = i % W;
            y  = i / W;
            nb = 0;
            while ($urandom_range(99) < bub_pct && nb < 4) begin
                step(1'b0, 1'($urandom_range(1)), 8'($urandom));
                nb++;
            end
            step(1'b1, sof_first && (i == 0), pix(x, y));
            if (x == 6 && y == 6) begin
                chk("first_x", 64'(bus.o_x), 64'd3);
                chk("first_y", 64'(bus.o_y), 64'd3);
                chk("first_col6", 64'(bus.o_col6), 64'h66564636261606);
                chk("first_col0", 64'(bus.o_col0), 64'h60504030201000);
            end
            if (y == 8 && x < 6) chk("wrap_novalid", 64'(bus.o_valid), 64'd0);
            if (x == 6 && y == 8) begin
                chk("wrap_y", 64'(bus.o_y), 64'd5);
                chk("wrap_col6", 64'(bus.o_col6), 64'h86766656463626);
            end
            if (x == W - 1 && y == H - 1) begin
                chk("end_valid", 64'(bus.o_valid), 64'd1);
                chk("end_last", 64'(bus.o_last), 64'd1);
                chk("end_x", 64'(bus.o_x), 64'd12);
                chk("end_y", 64'(bus.o_y), 64'd8);
            end
        end
    endtask

    initial begin
        int first;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_pixel = 8'h00;
        do_reset();

        // Continuous frame with sof.
        valid_cnt = 0;
        run_frame(0, 1'b1, W * H);
        chk("frame1_count", 64'(valid_cnt), 64'd60);

        // Same frame with random bubbles.
        valid_cnt = 0;
        run_frame(40, 1'b1, W * H);
        chk("bubble_count", 64'(valid_cnt), 64'd60);

        // Reset at pixel (9,8), then a fresh frame without sof.
        run_frame(0, 1'b1, 8 * W + 9);
        do_reset();
        valid_cnt = 0;
        run_frame(0, 1'b0, W * H);
        chk("reset_count", 64'(valid_cnt), 64'd60);

        // Resync: sof arrives at nominal (4,3).
        run_frame(0, 1'b1, 3 * W + 4);
        first = 0;
        for (int i = 0; i < 130; i++) begin
            int n;
            n = 3 * W + 4 + i;
            step(1'b1, i == 0, pix(n % W, (n / W) % H));
            if (bus.o_valid && first == 0) first = i + 1;
        end
        chk("resync_first", 64'(first), 64'd103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
